// File: rtl/load_align_unit_pkg.sv
// rtl/load_align_unit_pkg.sv - shared load types, state encoding and size lookup
package load_align_unit_pkg;

    // Load type encodings (funct3)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        WAIT0 = 3'd2,
        RD1   = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Access size in bytes; the low two funct3 bits encode log2(size)
    function automatic logic [3:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // ld and lwu only exist when the word is 64 bits wide
    function automatic logic funct3_legal(input logic [2:0] funct3, input int data_width);
        case (funct3)
            LB, LH, LW, LBU, LHU: return 1'b1;
            LD, LWU:              return (data_width == 64);
            default:              return 1'b0;
        endcase
    endfunction

    // ld fills the whole register, so it is treated as unsigned
    function automatic logic funct3_signed(input logic [2:0] funct3);
        return (!funct3[2]) && (funct3 != LD);
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - shift, extract and sign/zero-extend bytes from a two-word window
module load_extend
    import load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] word0_i,
    input  logic [DATA_WIDTH-1:0] word1_i,
    input  logic [OFF_W-1:0]      off_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] window;
    logic                  top_bit;
    int                    nbits;

    // Little-endian window starting at the addressed byte, then extend past nbits
    always_comb begin
        window  = DATA_WIDTH'({word1_i, word0_i} >> {off_i, 3'b000});
        nbits   = 8 * int'(access_size(funct3_i));
        if (nbits > DATA_WIDTH) begin
            nbits = DATA_WIDTH;
        end
        top_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == nbits - 1) begin
                top_bit = window[i];
            end
        end
        data_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < nbits) begin
                data_o[i] = window[i];
            end else begin
                data_o[i] = funct3_signed(funct3_i) & top_bit;
            end
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - multi-cycle load aligner; LOAD_ALIGN_MISALIGNED_SPLIT_EN enables two-read crossing loads
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  rsp_fault
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);

`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   word0_q, word0_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   word1;
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
    logic [DATA_WIDTH-1:0]   word1_q, word1_d;
`endif

    logic [OFF_W-1:0]        off;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic                    legal;
    logic                    crossing;
    logic                    reject;
    logic [DATA_WIDTH-1:0]   ext_data;

`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
    assign word1 = word1_q;
`else
    assign word1 = '0;
`endif

    assign off       = addr_q[OFF_W-1:0];
    assign base_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign legal     = funct3_legal(funct3_q, DATA_WIDTH);
    assign crossing  = (int'(off) + int'(access_size(funct3_q))) > BYTES;
    // Requests that never touch memory: bad funct3, or a crossing without split support
    assign reject    = !legal || (crossing && !SPLIT_EN);

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .word0_i  (word0_q),
        .word1_i  (word1),
        .off_i    (off),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing of the one- or two-read access
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = RD0;
            RD0:   state_d = reject ? RESP : WAIT0;
            WAIT0: begin
                if (mem_rvalid) begin
                    state_d = (SPLIT_EN && crossing) ? RD1 : RESP;
                end
            end
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
            RD1:   state_d = WAIT1;
            WAIT1: if (mem_rvalid) state_d = RESP;
`endif
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Captured request fields and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            funct3_q <= '0;
            tag_q    <= '0;
            word0_q  <= '0;
            fault_q  <= 1'b0;
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
            word1_q  <= '0;
`endif
        end else begin
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            tag_q    <= tag_d;
            word0_q  <= word0_d;
            fault_q  <= fault_d;
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
            word1_q  <= word1_d;
`endif
        end
    end

    // Capture on accept, flag rejects in RD0, latch data words on rvalid
    always_comb begin
        addr_d   = addr_q;
        funct3_d = funct3_q;
        tag_d    = tag_q;
        word0_d  = word0_q;
        fault_d  = fault_q;
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
        word1_d  = word1_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    tag_d    = req_tag;
                    word0_d  = '0;
                    fault_d  = 1'b0;
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
                    word1_d  = '0;
`endif
                end
            end
            RD0:   if (reject) fault_d = 1'b1;
            WAIT0: if (mem_rvalid) word0_d = mem_rdata;
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
            WAIT1: if (mem_rvalid) word1_d = mem_rdata;
`endif
            default: ;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        rsp_valid = 1'b0;
        rsp_fault = 1'b0;
        rsp_data  = '0;
        rsp_tag   = tag_q;
        case (state_q)
            RD0: begin
                if (!reject) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = base_addr;
                end
            end
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
            RD1: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_addr + ADDR_WIDTH'(BYTES);
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = fault_q;
                rsp_data  = fault_q ? '0 : ext_data;
            end
            default: ;
        endcase
    end

endmodule
